ts_link_sequencer: RTL

TS_LINK_SEQUENCER -- requirements
Module: ts_link_sequencer

---
 rtl/ts_link_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ts_link_sequencer.sv
// Bring-up sequencer for a two-link transceiver: resets the CPLL and both RX paths,
// checks comma/error health per link with polarity correction, and retries on failure.
module ts_link_sequencer #(
  parameter int CPLL_RST_CYCLES = 16,
  parameter int WAIT_TIMEOUT    = 125000,
  parameter int ALIGN_WINDOW    = 1024,
  parameter int MAX_ERR         = 4,
  parameter int MAX_RETRY       = 8
) (
  input  logic       clk125,
  input  logic       reset,
  input  logic       enable,
  input  logic       restart,
  input  logic [1:0] polarity_init,
  input  logic       cpll_locked,
  input  logic [1:0] rx_reset_done,
  input  logic [1:0] rx_err,
  input  logic [1:0] rx_comma,
  output logic       cpll_reset,
  output logic [1:0] reset_rx,
  output logic [1:0] polarity,
  output logic [1:0] link_up,
  output logic       failed,
  output logic [3:0] state,
  output logic [7:0] retry_count
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CPLL_RST  = 4'd1,
    S_WAIT_CPLL = 4'd2,
    S_RX_RST    = 4'd3,
    S_WAIT_DONE = 4'd4,
    S_CHECK     = 4'd5,
    S_LOCKED    = 4'd6,
    S_FAIL      = 4'd7,
    S_RETRY     = 4'd8
  } state_e;

  // One shared cycle counter serves every timed state; size it for the longest limit.
  localparam int CNT_MAX_A = (WAIT_TIMEOUT > ALIGN_WINDOW) ? WAIT_TIMEOUT : ALIGN_WINDOW;
  localparam int CNT_MAX   = (CNT_MAX_A > CPLL_RST_CYCLES) ? CNT_MAX_A : CPLL_RST_CYCLES;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(CPLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_TIMEOUT - 1);
  localparam logic [CW-1:0] WIN_LAST  = CW'(ALIGN_WINDOW - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      err_q [2];
  logic [7:0]      err_d [2];
  logic [7:0]      err_cur [2];
  logic [1:0]      comma_q, comma_d, comma_cur;
  logic [1:0]      pol_q, pol_d;
  logic [7:0]      retry_q, retry_d, retry_inc;
  logic [1:0]      good;
  logic            err_hit;
  logic            win_end;
  logic            enter;

  logic            cpll_reset_q;
  logic [1:0]      reset_rx_q;
  logic [1:0]      link_up_q;
  logic            failed_q;

  always_comb begin
    win_end   = (cnt_q == WIN_LAST);
    comma_cur = comma_q | rx_comma;
    err_hit   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      err_cur[i] = (rx_err[i] && err_q[i] != 8'hFF) ? err_q[i] + 8'd1 : err_q[i];
      good[i]    = (int'(err_cur[i]) < MAX_ERR) && comma_cur[i];
      if (int'(err_cur[i]) >= MAX_ERR) err_hit = 1'b1;
    end
    retry_inc = (retry_q == 8'hFF) ? 8'hFF : retry_q + 8'd1;
  end

  // Next-state logic; enable and restart override every state-internal transition.
  always_comb begin
    state_d = state_q;
    enter   = 1'b0;
    pol_d   = pol_q;
    retry_d = retry_q;
    if (!enable) begin
      state_d = S_IDLE;
      enter   = (state_q != S_IDLE);
    end else if (restart && state_q != S_IDLE) begin
      state_d = S_CPLL_RST;
      enter   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_CPLL_RST;
          enter   = 1'b1;
          pol_d   = polarity_init;
          retry_d = 8'd0;
        end
        S_CPLL_RST: if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_CPLL;
          enter   = 1'b1;
        end
        S_WAIT_CPLL: if (cpll_locked) begin
          state_d = S_RX_RST;
          enter   = 1'b1;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_RETRY;
          enter   = 1'b1;
        end
        S_RX_RST: if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_DONE;
          enter   = 1'b1;
        end
        S_WAIT_DONE: if (rx_reset_done == 2'b11) begin
          state_d = S_CHECK;
          enter   = 1'b1;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_RETRY;
          enter   = 1'b1;
        end
        S_CHECK: if (win_end) begin
          enter = 1'b1;
          if (&good) begin
            state_d = S_LOCKED;
          end else begin
            pol_d   = pol_q ^ ~good;
            state_d = S_RETRY;
          end
        end
        S_LOCKED: if (!cpll_locked || rx_reset_done != 2'b11 || err_hit) begin
          state_d = S_RETRY;
          enter   = 1'b1;
        end
        S_RETRY: begin
          retry_d = retry_inc;
          enter   = 1'b1;
          state_d = (int'(retry_inc) >= MAX_RETRY) ? S_FAIL : S_CPLL_RST;
        end
        S_FAIL:  state_d = S_FAIL;
        default: begin
          state_d = S_IDLE;
          enter   = 1'b1;
        end
      endcase
    end
  end

  // Counters restart on every transition; LOCKED also rolls them at each window end.
  always_comb begin
    if (enter || state_q == S_IDLE || state_q == S_FAIL ||
        (state_q == S_LOCKED && win_end))
      cnt_d = '0;
    else
      cnt_d = cnt_q + CW'(1);
    for (int i = 0; i < 2; i++) begin
      if (enter || win_end || !(state_q == S_CHECK || state_q == S_LOCKED)) begin
        err_d[i]   = 8'd0;
        comma_d[i] = 1'b0;
      end else begin
        err_d[i]   = err_cur[i];
        comma_d[i] = comma_cur[i];
      end
    end
  end

  // Output flops are loaded from the next state so they line up with the state register.
  always_ff @(posedge clk125) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      err_q[0]     <= 8'd0;
      err_q[1]     <= 8'd0;
      comma_q      <= 2'b00;
      pol_q        <= 2'b00;
      retry_q      <= 8'd0;
      cpll_reset_q <= 1'b0;
      reset_rx_q   <= 2'b00;
      link_up_q    <= 2'b00;
      failed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q[0]     <= err_d[0];
      err_q[1]     <= err_d[1];
      comma_q      <= comma_d;
      pol_q        <= pol_d;
      retry_q      <= retry_d;
      cpll_reset_q <= (state_d == S_CPLL_RST);
      reset_rx_q   <= (state_d == S_CPLL_RST || state_d == S_WAIT_CPLL ||
                       state_d == S_RX_RST) ? 2'b11 : 2'b00;
      link_up_q    <= (state_d == S_LOCKED) ? 2'b11 : 2'b00;
      failed_q     <= (state_d == S_FAIL);
    end
  end

  assign cpll_reset  = cpll_reset_q;
  assign reset_rx    = reset_rx_q;
  assign polarity    = pol_q;
  assign link_up     = link_up_q;
  assign failed      = failed_q;
  assign state       = state_q;
  assign retry_count = retry_q;

endmodule
